// File: rtl/multi_road_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_road_light_ctrl
// Brief    : N-road traffic-light controller with min/max green, amber and
//            all-red clearance timers; round-robin grant on waiting requests.
// Revision : 1.0  initial release
// ============================================================================
module multi_road_light_ctrl #(
  parameter int NUM_ROADS      = 4,
  parameter int CNT_W          = 8,
  parameter int MIN_GREEN      = 8,
  parameter int MAX_GREEN      = 32,
  parameter int AMBER_CYCLES   = 4,
  parameter int ALL_RED_CYCLES = 2,
  localparam int IDX_W         = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_ROADS-1:0] req,
  output logic [NUM_ROADS-1:0] green,
  output logic [NUM_ROADS-1:0] amber,
  output logic [NUM_ROADS-1:0] red,
  output logic [IDX_W-1:0]     active_road,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_AMBER   = 2'b01,
    PH_ALL_RED = 2'b10
  } phase_t;

  localparam logic [CNT_W-1:0] C_MIN_LAST     = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_MAX_LAST     = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] C_AMBER_LAST   = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ALL_RED_LAST = CNT_W'((ALL_RED_CYCLES > 0) ? ALL_RED_CYCLES - 1 : 0);
  localparam logic [IDX_W:0]   C_NUM          = (IDX_W + 1)'(NUM_ROADS);

  phase_t               r_phase;
  phase_t               w_phase_nxt;
  logic [IDX_W-1:0]     r_active;
  logic [IDX_W-1:0]     w_active_nxt;
  logic [IDX_W-1:0]     r_next;
  logic [IDX_W-1:0]     w_next_nxt;
  logic [IDX_W-1:0]     w_winner;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_ROADS-1:0] w_active_oh;
  logic [NUM_ROADS-1:0] w_others;
  logic                 w_other_req;
  logic                 w_own_req;
  logic                 w_found;
  logic                 w_gap_out;
  logic                 w_max_out;
  logic [IDX_W:0]       w_sum;

  assign w_active_oh = NUM_ROADS'(1) << r_active;
  assign w_others    = req & ~w_active_oh;
  assign w_other_req = |w_others;
  assign w_own_req   = |(req & w_active_oh);
  assign w_gap_out   = (r_cnt >= C_MIN_LAST) && !w_own_req;
  assign w_max_out   = (r_cnt == C_MAX_LAST);

  // Round-robin scan starting just after the active road, wrapping modulo NUM_ROADS.
  always_comb begin
    w_winner = r_active;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int i = 1; i < NUM_ROADS; i++) begin
      w_sum = {1'b0, r_active} + (IDX_W + 1)'(i);
      if (w_sum >= C_NUM) begin
        w_sum = w_sum - C_NUM;
      end
      if (!w_found && req[w_sum[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_active_nxt = r_active;
    w_next_nxt   = r_next;
    w_cnt_nxt    = r_cnt;
    case (r_phase)
      PH_GREEN: begin
        if (w_other_req && (w_gap_out || w_max_out)) begin
          w_phase_nxt = PH_AMBER;
          w_next_nxt  = w_winner;
          w_cnt_nxt   = '0;
        end else if (!w_max_out) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PH_AMBER: begin
        if (r_cnt == C_AMBER_LAST) begin
          w_cnt_nxt = '0;
          // A zero-length clearance hands green straight to the latched road.
          if (ALL_RED_CYCLES == 0) begin
            w_phase_nxt  = PH_GREEN;
            w_active_nxt = r_next;
          end else begin
            w_phase_nxt = PH_ALL_RED;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PH_ALL_RED: begin
        if (r_cnt == C_ALL_RED_LAST) begin
          w_phase_nxt  = PH_GREEN;
          w_active_nxt = r_next;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_phase_nxt = PH_GREEN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase  <= PH_GREEN;
      r_active <= '0;
      r_next   <= '0;
      r_cnt    <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_active <= w_active_nxt;
      r_next   <= w_next_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign green       = (r_phase == PH_GREEN) ? w_active_oh : '0;
  assign amber       = (r_phase == PH_AMBER) ? w_active_oh : '0;
  assign red         = ~(green | amber);
  assign active_road = r_active;
  assign phase       = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_multi_road_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_road_light_ctrl
// Brief    : Directed scoreboard bench for multi_road_light_ctrl (with and
//            without all-red clearance).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_road_light_ctrl;

  localparam logic [1:0] PG = 2'b00;
  localparam logic [1:0] PA = 2'b01;
  localparam logic [1:0] PR = 2'b10;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_a, req_b;
  logic [3:0] g_a, a_a, r_a, g_b, a_b, r_b;
  logic [1:0] act_a, ph_a, act_b, ph_b;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  multi_road_light_ctrl #(
    .NUM_ROADS(4), .CNT_W(8), .MIN_GREEN(4), .MAX_GREEN(8),
    .AMBER_CYCLES(3), .ALL_RED_CYCLES(2)
  ) u_dut (
    .clk(clk), .rstn(rstn), .req(req_a), .green(g_a), .amber(a_a),
    .red(r_a), .active_road(act_a), .phase(ph_a)
  );

  multi_road_light_ctrl #(
    .NUM_ROADS(4), .CNT_W(8), .MIN_GREEN(4), .MAX_GREEN(8),
    .AMBER_CYCLES(3), .ALL_RED_CYCLES(0)
  ) u_dut_nr (
    .clk(clk), .rstn(rstn), .req(req_b), .green(g_b), .amber(a_b),
    .red(r_b), .active_road(act_b), .phase(ph_b)
  );

  // Expected {green, amber, red, phase, active_road} for a given phase/road.
  function automatic logic [15:0] expect_vec(input logic [1:0] ph, input logic [1:0] act);
    logic [3:0] oh, g, a;
    oh = 4'b0001 << act;
    g  = (ph == PG) ? oh : 4'b0000;
    a  = (ph == PA) ? oh : 4'b0000;
    return {g, a, ~(g | a), ph, act};
  endfunction

  function automatic logic [15:0] observed(input bit sel);
    return sel ? {g_b, a_b, r_b, ph_b, act_b} : {g_a, a_a, r_a, ph_a, act_a};
  endfunction

  task automatic check_sb(input bit sel, input string tag);
    logic [15:0] e, o;
    e = sb_q.pop_front();
    o = observed(sel);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed g/a/r/ph/act=%h expected=%h", tag, o, e);
    end
  endtask

  // Hold req for n cycles; each cycle the post-edge lamp state must match.
  task automatic run(input bit sel, input logic [3:0] r, input int n,
                     input logic [1:0] ph, input logic [1:0] act, input string tag);
    for (int k = 0; k < n; k++) begin
      if (sel) req_b = r;
      else     req_a = r;
      sb_q.push_back(expect_vec(ph, act));
      @(posedge clk);
      #1;
      check_sb(sel, tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn  = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    #1;
    sb_q.push_back(expect_vec(PG, 2'd0));
    check_sb(1'b0, "reset_a");
    sb_q.push_back(expect_vec(PG, 2'd0));
    check_sb(1'b1, "reset_b");
    #2 rstn = 1'b1;

    run(0, 4'b0000, 50, PG, 2'd0, "idle_hold");
    n_total++;
    assert (u_dut.r_cnt === 8'd7) n_pass++;
    else begin
      n_fail++;
      $error("FAIL cnt_sat: observed cnt=%0d expected=7", u_dut.r_cnt);
    end

    // Saturated road 0, single-cycle request from road 2.
    run(0, 4'b0100, 1, PA, 2'd0, "sat_exit");
    run(0, 4'b0000, 2, PA, 2'd0, "amber0");
    run(0, 4'b0000, 2, PR, 2'd0, "allred0");

    // Road 2 keeps requesting alongside road 3: max-out after 8 cycles.
    run(0, 4'b1100, 1, PG, 2'd2, "green2_start");
    run(0, 4'b1100, 7, PG, 2'd2, "green2_max");
    run(0, 4'b1100, 3, PA, 2'd2, "amber2");
    run(0, 4'b1100, 2, PR, 2'd2, "allred2");

    // Road 3 gaps out; roads 1 and 2 wait, winner wraps past 0 to 1.
    run(0, 4'b0110, 4, PG, 2'd3, "green3_min");
    run(0, 4'b0110, 3, PA, 2'd3, "amber3");
    run(0, 4'b0110, 2, PR, 2'd3, "allred3");

    run(0, 4'b0001, 4, PG, 2'd1, "green1_wrap");
    run(0, 4'b0001, 3, PA, 2'd1, "amber1");
    run(0, 4'b0001, 2, PR, 2'd1, "allred1");

    // Road 1 request withdrawn during amber still gets its green.
    run(0, 4'b0010, 4, PG, 2'd0, "green0");
    run(0, 4'b0010, 1, PA, 2'd0, "amber0_req");
    run(0, 4'b0000, 2, PA, 2'd0, "amber0_drop");
    run(0, 4'b0000, 2, PR, 2'd0, "allred0_drop");
    run(0, 4'b0000, 4, PG, 2'd1, "green1_latched");

    // Move to road 2, then reset in the middle of road 2 amber.
    run(0, 4'b0100, 1, PA, 2'd1, "to2_exit");
    run(0, 4'b0000, 2, PA, 2'd1, "to2_amber");
    run(0, 4'b0000, 2, PR, 2'd1, "to2_allred");
    run(0, 4'b0001, 4, PG, 2'd2, "green2_gap");
    run(0, 4'b0001, 1, PA, 2'd2, "amber2_pre_rst");
    #2 rstn = 1'b0;
    #1;
    sb_q.push_back(expect_vec(PG, 2'd0));
    check_sb(1'b0, "async_reset");
    @(negedge clk);
    rstn  = 1'b1;
    req_a = 4'b0000;
    run(0, 4'b0000, 3, PG, 2'd0, "post_reset");

    // No all-red variant: amber hands directly to green.
    run(1, 4'b0000, 5, PG, 2'd0, "nr_idle");
    run(1, 4'b0010, 1, PA, 2'd0, "nr_exit");
    run(1, 4'b0000, 2, PA, 2'd0, "nr_amber");
    run(1, 4'b0000, 3, PG, 2'd1, "nr_green1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_road_light_ctrl.md
# multi_road_light_ctrl

Parametrised N-road traffic-light controller with on-board phase timers. Each road owns one vehicle-request sensor and one red/amber/green lamp set. The block grants green to one road at a time, guarantees a minimum green, extends green up to a maximum while the served road keeps requesting, and inserts fixed amber and all-red clearance phases. Lamps drive directly from it, with no external timer.

## Interface
- NUM_ROADS, 4, number of roads; legal range 2..16
- CNT_W, 8, phase counter width
- MIN_GREEN, 8, minimum green length in cycles; 1 ≤ MIN_GREEN ≤ MAX_GREEN
- MAX_GREEN, 32, maximum green length in cycles while another road waits; must be < 2^CNT_W
- AMBER_CYCLES, 4, amber length in cycles; ≥1 and < 2^CNT_W
- ALL_RED_CYCLES, 2, all-red clearance length in cycles; 0 skips the phase
- clk  in  1  single system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- req  in  NUM_ROADS  vehicle present per road; synchronous to clk
- green  out  NUM_ROADS  green lamp per road
- amber  out  NUM_ROADS  amber lamp per road
- red  out  NUM_ROADS  red lamp per road
- active_road  out  max(1,$clog2(NUM_ROADS))  index of the road owning the current green/amber
- phase  out  2  00 GREEN, 01 AMBER, 10 ALL_RED; 11 is never driven

## Operation
- Registers: phase, active_road, next_road, cnt (CNT_W). All outputs decode from these registers only (Moore). There is no combinational path from req to any output.
- Lamps: for every road, exactly one of red/amber/green is high. The active road is green in GREEN and amber in AMBER. All other roads, and every road in ALL_RED, are red.
- Reset (rstn low, async): phase=GREEN, active_road=0, next_road=0, cnt=0. This gives green[0]=1, red[all others]=1, amber=0. Reset takes effect immediately in any state.
- other_req = OR of req over all roads except active_road.
- GREEN:
  - cnt increments each cycle and saturates at MAX_GREEN-1.
  - Exit when other_req and one of the following holds:
    - cnt ≥ MIN_GREEN-1 and req[active_road]=0 (gap-out), or
    - cnt == MAX_GREEN-1 (max-out).
  - With no other_req, stay green indefinitely.
  - On exit: next_road gets the round-robin winner, phase=AMBER, cnt=0.
- Round-robin winner: first index with req high, scanning active_road+1, +2, … modulo NUM_ROADS. The active road itself is excluded.
- AMBER:
  - Lasts exactly AMBER_CYCLES cycles.
  - When cnt==AMBER_CYCLES-1: phase=ALL_RED and cnt=0. If ALL_RED_CYCLES=0, instead go straight to GREEN with active_road=next_road.
- ALL_RED:
  - Lasts exactly ALL_RED_CYCLES cycles.
  - Then phase=GREEN, active_road=next_road, cnt=0.
- req is ignored in AMBER and ALL_RED. The target road is latched at GREEN exit; withdrawal of its request does not cancel the switch.

## Timing
- req is sampled at the rising edge. The exit decision at edge k makes amber visible after edge k, so green lasts at least MIN_GREEN cycles.
- Green length under a waiting request:
  - Gap-out: max(MIN_GREEN, cycles until own req drops).
  - Max-out: MAX_GREEN, counted from green start.
- If a request arrives after saturation, exit happens at the next edge. The amber starts 1 cycle after the request is sampled.
- Green-to-green switch time: AMBER_CYCLES + ALL_RED_CYCLES cycles with no green lamp anywhere.
- Simultaneous requests: resolved solely by round-robin order from active_road+1.
- Deassertion of rstn: first state change can occur at the first rising edge after release.

## Test plan
Common configuration: NUM_ROADS=4, MIN_GREEN=4, MAX_GREEN=8, AMBER_CYCLES=3, ALL_RED_CYCLES=2.

- Reset, req=0000 for 50 cycles -> green[0]=1, red[3:1]=111, phase=00 throughout; cnt holds at 7.
- Saturated road 0, req[0]=0, req=0100 asserted for 1 cycle -> 3 cycles amber[0], 2 cycles all red, then green[2], active_road=2.
- Road 2 green from cycle 0, req[2]=1 and req[3]=1 held -> green[2] for exactly 8 cycles, then amber[2] for 3, all red for 2, then green[3].
- Active road 3, req=0110 at exit -> next green is road 1 (wrap past 0, lowest after 3).
- Road 0 green with req=0010; req[1] dropped during amber -> sequence completes, green[1] still granted.
- rstn pulsed low during AMBER of road 2 -> same cycle: green[0]=1, amber=0000, phase=00, active_road=0. ALL_RED_CYCLES=0 variant: amber is followed directly by green with no all-red cycle.
